store_buffer: RTL and testbench
===============================

# store_buffer

Word-granular store buffer between the MEM pipeline stage and the data memory. Retiring stores enter a circular FIFO and drain to the data memory one per cycle whenever the memory port is not claimed by a load. Loads are checked against all buffered entries and forwarded from the youngest matching store, so the pipeline never sees stale data.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- ADDR_WIDTH, 32, store/load address width
- DATA_WIDTH, 32, store data width

Ports:
- clock  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- storeValid  input  1  MEM stage presents a store this cycle
- storeAddress  input  ADDR_WIDTH  word address of the store
- storeData  input  DATA_WIDTH  store data
- storeReady  output  1  buffer can accept a store this cycle
- loadValid  input  1  MEM stage presents a load this cycle
- loadAddress  input  ADDR_WIDTH  word address of the load
- loadHit  output  1  loadValid and a buffered entry matches loadAddress
- loadHitData  output  DATA_WIDTH  data of youngest matching entry; 0 when no hit
- memoryBusy  input  1  data memory port claimed by a load this cycle
- memoryWrite  output  1  drain strobe to data memory
- memoryAddress  output  ADDR_WIDTH  head entry address
- memoryWriteData  output  DATA_WIDTH  head entry data
- empty  output  1  no entries buffered

## Operation
- State: DEPTH entries {address, data}, headPtr, tailPtr (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits, 0..DEPTH).
- storeReady = (count != DEPTH). No pass-through when full, even if a drain occurs that cycle.
- Push: storeValid && storeReady → entry[tailPtr] written, tailPtr+1, count+1 at the edge.
- storeValid && !storeReady: store ignored, no state change. Upstream must hold the store and stall.
- Drain: memoryWrite = !empty && !memoryBusy, combinational. memoryAddress/memoryWriteData always show entry[headPtr]; they are 0 when empty. On a drain, headPtr+1 and count−1 at the edge.
- Push and drain in the same cycle: count unchanged; both pointers advance.
- Forwarding: compare loadAddress against all valid entries. loadHitData comes from the youngest match, counting back from tailPtr−1. The head entry draining this cycle still participates. A store pushed this cycle is not visible to a load in the same cycle.
- loadHit = 0 whenever loadValid = 0.

## Timing
- Reset values: headPtr = tailPtr = count = 0. Outputs: storeReady = 1, empty = 1, memoryWrite = 0, loadHit = 0, loadHitData = 0, memoryAddress = 0, memoryWriteData = 0. Entry storage is not cleared.
- Reset asserted mid-operation discards all buffered stores at that edge. Reset has priority over push and drain.
- Store-to-drain latency: the earliest drain is the cycle after the push, with memoryBusy low.
- Store-to-forward latency: 1 cycle. The entry becomes visible from the cycle after the push.
- loadHit, loadHitData, memoryWrite and storeReady are combinational from current state and inputs. No input-to-output path exists through storage writes.
- Drain order is strictly FIFO. Throughput is one drain per unbusy cycle.

## Configuration
- STORE_BUFFER_COALESCE_EN defined:
  - A store is coalesced when its storeAddress equals the address of the youngest entry (tailPtr−1), count ≥ 1, and that entry is not the head draining this cycle.
  - A coalesced store overwrites that entry's data in place; pointers and count are unchanged.
  - Coalescing is allowed even when full, so storeReady = !full || coalesce-match.
- Undefined: every accepted store allocates a new entry; storeReady = !full.

## Structure
- Package store_buffer_pkg:
  - sb_entry_t typedef {address, data}.
  - Default DEPTH/ADDR_WIDTH/DATA_WIDTH constants.
  - Pointer/count width helper constants.
- Sub-module store_buffer_match: parallel address compare, then youngest-first priority select given tailPtr and count; outputs hit and data.
- Top level owns the storage array, pointers, counter, drain logic and the coalesce ifdef.

## Test plan
- Reset, then 3 stores (A=0x10/0x11, A=0x14/0x22, A=0x18/0x33) with memoryBusy=1 → count=3, memoryWrite=0. Release memoryBusy → writes 0x10, 0x14, 0x18 on consecutive cycles, then empty=1.
- Fill 4 entries with memoryBusy=1 → storeReady=0. A 5th store is ignored. One drain then restores storeReady=1 the next cycle.
- Stores 0x20/0xAA then 0x20/0xBB with a load of 0x20 the following cycle → loadHit=1, loadHitData=0xBB. Load of 0x24 → loadHit=0, loadHitData=0.
- Push and drain in the same cycle at count=2 → count stays 2. Run pointer wrap-around over ≥ 2·DEPTH stores; order is preserved.
- Assert reset with 3 entries buffered → next cycle empty=1, memoryWrite=0, loadHit=0 for a previously buffered address.
- With STORE_BUFFER_COALESCE_EN: two back-to-back stores to 0x30 → count=1 and a single drain of the second value. Without the macro → count=2 and two drains.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and sizing helpers for the store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH      = 4;
  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_WIDTH = 32;

  // Entry layout at the default widths.
  typedef struct packed {
    logic [SB_ADDR_WIDTH-1:0] address;
    logic [SB_DATA_WIDTH-1:0] data;
  } sb_entry_t;

  // Pointer width; kept at least 1 so degenerate depths still elaborate.
  function automatic int sb_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count must hold 0..DEPTH, so one bit wider than a pointer.
  function automatic int sb_cnt_width(input int depth);
    return sb_ptr_width(depth) + 1;
  endfunction

  localparam int SB_PTR_W = sb_ptr_width(SB_DEPTH);
  localparam int SB_CNT_W = sb_cnt_width(SB_DEPTH);

endpackage

// File: rtl/store_buffer_match.sv
// Load forwarding: compares the load address against every buffered entry
// and returns the data of the youngest valid match.
import store_buffer_pkg::*;

module store_buffer_match #(
  parameter int DEPTH      = SB_DEPTH,
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SB_DATA_WIDTH,
  parameter int PTR_W      = sb_ptr_width(DEPTH),
  parameter int CNT_W      = sb_cnt_width(DEPTH)
) (
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_address,
  input  logic [ADDR_WIDTH-1:0] entry_address [DEPTH],
  input  logic [DATA_WIDTH-1:0] entry_data    [DEPTH],
  input  logic [PTR_W-1:0]      tail_ptr,
  input  logic [CNT_W-1:0]      count,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] hit_data
);

  logic [DEPTH-1:0] addr_eq;
  logic [PTR_W-1:0] idx;

  // Parallel address compare against every physical slot.
  always_comb begin
    addr_eq = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_eq[i] = (entry_address[i] == load_address);
    end
  end

  // Walk oldest to youngest (age DEPTH..1 behind tail) so younger matches override.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int age = DEPTH; age >= 1; age--) begin
      idx = tail_ptr - PTR_W'(age);
      if ((CNT_W'(age) <= count) && addr_eq[idx]) begin
        hit      = 1'b1;
        hit_data = entry_data[idx];
      end
    end
    if (!load_valid) begin
      hit      = 1'b0;
      hit_data = '0;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Word-granular circular store buffer with youngest-match load forwarding.
// Optional feature macro: STORE_BUFFER_COALESCE_EN merges a store into the
// youngest entry when the addresses match.
import store_buffer_pkg::*;

module store_buffer #(
  parameter int DEPTH      = SB_DEPTH,
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SB_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  storeValid,
  input  logic [ADDR_WIDTH-1:0] storeAddress,
  input  logic [DATA_WIDTH-1:0] storeData,
  output logic                  storeReady,
  input  logic                  loadValid,
  input  logic [ADDR_WIDTH-1:0] loadAddress,
  output logic                  loadHit,
  output logic [DATA_WIDTH-1:0] loadHitData,
  input  logic                  memoryBusy,
  output logic                  memoryWrite,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  output logic [DATA_WIDTH-1:0] memoryWriteData,
  output logic                  empty
);

  localparam int PTR_W = sb_ptr_width(DEPTH);
  localparam int CNT_W = sb_cnt_width(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [PTR_W-1:0]      youngest_ptr;
  logic                  is_empty;
  logic                  is_full;
  logic                  do_drain;
  logic                  do_push;
  logic                  do_coalesce;

  assign is_empty     = (count_q == '0);
  assign is_full      = (count_q == CNT_FULL);
  assign youngest_ptr = tail_q - PTR_ONE;
  assign do_drain     = !is_empty && !memoryBusy;

  // Store acceptance: allocate a new slot, or merge into the youngest one.
`ifdef STORE_BUFFER_COALESCE_EN
  logic coalesce_match;
  // The youngest entry is only mergeable if it is not leaving this cycle.
  always_comb begin
    coalesce_match = !is_empty
                     && (mem_q[youngest_ptr].address == storeAddress)
                     && !(do_drain && (youngest_ptr == head_q));
    storeReady     = !is_full || coalesce_match;
    do_coalesce    = storeValid && coalesce_match;
    do_push        = storeValid && !coalesce_match && !is_full;
  end
`else
  // Every accepted store takes a fresh slot.
  always_comb begin
    storeReady  = !is_full;
    do_coalesce = 1'b0;
    do_push     = storeValid && !is_full;
  end
`endif

  // Drain port presents the head entry, zeroed while empty.
  always_comb begin
    memoryWrite     = do_drain;
    memoryAddress   = is_empty ? '0 : mem_q[head_q].address;
    memoryWriteData = is_empty ? '0 : mem_q[head_q].data;
    empty           = is_empty;
  end

  // Flatten storage for the forwarding compare.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr[i] = mem_q[i].address;
      ent_data[i] = mem_q[i].data;
    end
  end

  store_buffer_match #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_W      (PTR_W),
    .CNT_W      (CNT_W)
  ) u_match (
    .load_valid    (loadValid),
    .load_address  (loadAddress),
    .entry_address (ent_addr),
    .entry_data    (ent_data),
    .tail_ptr      (tail_q),
    .count         (count_q),
    .hit           (loadHit),
    .hit_data      (loadHitData)
  );

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[tail_q].address = storeAddress;
      mem_d[tail_q].data    = storeData;
      tail_d                = tail_q + PTR_ONE;
    end
    if (do_coalesce) begin
      mem_d[youngest_ptr].data = storeData;
    end
    if (do_drain) begin
      head_d = head_q + PTR_ONE;
    end
    if (do_push && !do_drain) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_push && do_drain) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Control state; reset discards everything buffered.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never cleared; stale slots are masked by count.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        storeValid;
  logic [31:0] storeAddress;
  logic [31:0] storeData;
  logic        storeReady;
  logic        loadValid;
  logic [31:0] loadAddress;
  logic        loadHit;
  logic [31:0] loadHitData;
  logic        memoryBusy;
  logic        memoryWrite;
  logic [31:0] memoryAddress;
  logic [31:0] memoryWriteData;
  logic        empty;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t mq[$];

  always #5 clock = ~clock;

  store_buffer dut (
    .clock           (clock),
    .reset           (reset),
    .storeValid      (storeValid),
    .storeAddress    (storeAddress),
    .storeData       (storeData),
    .storeReady      (storeReady),
    .loadValid       (loadValid),
    .loadAddress     (loadAddress),
    .loadHit         (loadHit),
    .loadHitData     (loadHitData),
    .memoryBusy      (memoryBusy),
    .memoryWrite     (memoryWrite),
    .memoryAddress   (memoryAddress),
    .memoryWriteData (memoryWriteData),
    .empty           (empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la, input logic busy,
                       input logic rst);
    storeValid   = sv;
    storeAddress = sa;
    storeData    = sd;
    loadValid    = lv;
    loadAddress  = la;
    memoryBusy   = busy;
    reset        = rst;
  endtask

  // Check all outputs against the queue model, clock once, update the model.
  task automatic step();
    int          n;
    logic        e_mw, e_hit, match, e_rdy;
    logic [31:0] e_hd;
    #1;
    n     = mq.size();
    e_mw  = (n != 0) && !memoryBusy;
    e_hit = 1'b0;
    e_hd  = '0;
    match = 1'b0;
    if (loadValid) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (mq[i].a == loadAddress) begin
          e_hit = 1'b1;
          e_hd  = mq[i].d;
          break;
        end
      end
    end
`ifdef STORE_BUFFER_COALESCE_EN
    match = (n >= 1) && (mq[n-1].a == storeAddress) && !(e_mw && n == 1);
`endif
    e_rdy = (n != DEPTH) || match;
    chk("empty",       empty,           n == 0);
    chk("storeReady",  storeReady,      e_rdy);
    chk("memoryWrite", memoryWrite,     e_mw);
    chk("memAddr",     memoryAddress,   n ? mq[0].a : 32'h0);
    chk("memData",     memoryWriteData, n ? mq[0].d : 32'h0);
    chk("loadHit",     loadHit,         e_hit);
    chk("loadHitData", loadHitData,     e_hd);
    @(posedge clock);
    if (reset) begin
      mq.delete();
    end else begin
      if (e_mw) void'(mq.pop_front());
      if (storeValid && e_rdy) begin
        if (match) mq[mq.size()-1].d = storeData;
        else       mq.push_back('{a: storeAddress, d: storeData});
      end
    end
    #1;
  endtask

  initial begin
    int drains;
    int exp_drains;
    logic [31:0] last;

    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clock);
    #1;
    mq.delete();
    drive(0, 0, 0, 1, 32'h0, 0, 0);
    #1;
    chk("rst_ready",  storeReady,      1);
    chk("rst_empty",  empty,           1);
    chk("rst_mw",     memoryWrite,     0);
    chk("rst_hit",    loadHit,         0);
    chk("rst_hd",     loadHitData,     0);
    chk("rst_maddr",  memoryAddress,   0);
    chk("rst_mdata",  memoryWriteData, 0);

    // Three stores held by a busy memory, then in-order drain.
    drive(1, 32'h10, 32'h11, 0, 0, 1, 0); step();
    drive(1, 32'h14, 32'h22, 0, 0, 1, 0); step();
    drive(1, 32'h18, 32'h33, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0); #1;
    chk("busy_no_write", memoryWrite, 0);
    chk("count3", mq.size(), 3);
    step();
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("drain0", memoryAddress, 32'h10); step();
    chk("drain1", memoryAddress, 32'h14); step();
    chk("drain2", memoryAddress, 32'h18); step();
    chk("drained_empty", empty, 1);

    // Fill to capacity; a fifth store is dropped; one drain reopens the buffer.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 0, 0, 1, 0); step();
    end
    drive(1, 32'h200, 32'hDEAD, 1, 32'h200, 1, 0); #1;
    chk("full_not_ready", storeReady, 0);
    step();
    drive(0, 0, 0, 1, 32'h200, 0, 0); step();
    drive(0, 0, 0, 0, 0, 1, 0); #1;
    chk("ready_after_drain", storeReady, 1);
    step();
    while (mq.size() != 0) begin drive(0, 0, 0, 0, 0, 0, 0); step(); end

    // Youngest-match forwarding.
    drive(1, 32'h20, 32'hAA, 0, 0, 1, 0); step();
    drive(1, 32'h20, 32'hBB, 0, 0, 1, 0); step();
    drive(0, 0, 0, 1, 32'h20, 1, 0); #1;
    chk("fwd_hit",  loadHit,     1);
    chk("fwd_data", loadHitData, 32'hBB);
    step();
    drive(0, 0, 0, 1, 32'h24, 1, 0); #1;
    chk("fwd_miss_hit",  loadHit,     0);
    chk("fwd_miss_data", loadHitData, 0);
    step();
    while (mq.size() != 0) begin drive(0, 0, 0, 0, 0, 0, 0); step(); end

    // Push and drain together at count 2 leaves count at 2.
    drive(1, 32'h50, 32'h1, 0, 0, 1, 0); step();
    drive(1, 32'h54, 32'h2, 0, 0, 1, 0); step();
    drive(1, 32'h58, 32'h3, 0, 0, 0, 0); step();
    chk("push_drain_count", mq.size(), 2);
    drive(1, 32'h5C, 32'h4, 0, 0, 1, 0); step();
    drive(1, 32'h60, 32'h5, 0, 0, 1, 0); #1;
    chk("push_drain_ready", storeReady, 1);
    step();
    drive(0, 0, 0, 0, 0, 1, 0); #1;
    chk("push_drain_full", storeReady, 0);
    step();

    // Reset with entries buffered discards them.
    drive(0, 0, 0, 1, 32'h58, 1, 1); step();
    drive(0, 0, 0, 1, 32'h58, 0, 0); #1;
    chk("mid_rst_empty", empty,       1);
    chk("mid_rst_mw",    memoryWrite, 0);
    chk("mid_rst_hit",   loadHit,     0);
    step();

    // Back-to-back stores to one address: merged or allocated.
    drive(1, 32'h30, 32'h1, 0, 0, 1, 0); step();
    drive(1, 32'h30, 32'h2, 0, 0, 1, 0); step();
`ifdef STORE_BUFFER_COALESCE_EN
    exp_drains = 1;
`else
    exp_drains = 2;
`endif
    drains = 0;
    last   = '0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0); #1;
      if (memoryWrite === 1'b1) begin drains++; last = memoryWriteData; end
      step();
    end
    chk("coalesce_drains", drains, exp_drains);
    chk("coalesce_last",   last,   32'h2);

    // Randomized traffic over a small address pool, with wrap-around and resets.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, 32'($urandom_range(0, 5)) << 2, $urandom,
            $urandom_range(0, 1), 32'($urandom_range(0, 5)) << 2,
            $urandom_range(0, 9) < 4, $urandom_range(0, 79) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
